jk_drive_ctrl: RTL and testbench
================================

# jk_drive_ctrl

Command sequencer sitting directly upstream of the master-slave JK flip-flop. Accepts queued flip-flop operations (hold/reset/set/toggle) over a valid/ready handshake, drives the flop's `Set`/`Reset` (J/K) inputs with correctly shaped single-cycle pulses, and waits a settle window. It then samples the flop's slave output `Qs` against a tracked expected value and reports completion and mismatch. It also owns the flop's `clear` line.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `SETTLE`, 2: cycles between end of J/K pulse and `Qs` sample; ≥1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_op`  in  2  `00` hold, `01` reset, `10` set, `11` toggle.
- `cmd_ready`  out  1  `~fifo_full`; transfer when `cmd_valid && cmd_ready` at a rising edge.
- `Set`  out  1  J input of flop (registered).
- `Reset`  out  1  K input of flop (registered).
- `ff_clear`  out  1  active-high clear to flop (registered).
- `Qs`  in  1  slave output of flop, synchronous to `clk`.
- `q_exp`  out  1  expected flop state after the last completed command.
- `done`  out  1  one-cycle pulse per completed command.
- `err`  out  1  one-cycle pulse coincident with `done` on mismatch.
- `busy`  out  1  high whenever state ≠ IDLE.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset (`clear_n`=0, asynchronous):
  - FIFO emptied; `level`=0, so `cmd_ready`=1.
  - `Set`=`Reset`=0, `done`=`err`=0, `busy`=0, `q_exp`=0, `ff_clear`=1, state IDLE.
  - `ff_clear` deasserts at the first rising edge after `clear_n` rises.
- FIFO:
  - Push on valid&ready. `cmd_op` is ignored otherwise.
  - When full, `cmd_ready`=0 even if a pop happens in the same cycle; no push while full.
  - A pop from IDLE and a push may occur on the same edge; `level` is unchanged.
  - Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, ISSUE, SETTLE.
  - IDLE: if the FIFO is non-empty (and `ff_clear`=0), pop the head and go to ISSUE.
    - `Set`/`Reset` are loaded from the op: hold `00`, reset `01`, set `10`, toggle `11`.
    - The expected next value is latched: hold keeps `q_exp`, reset 0, set 1, toggle `~q_exp`.
  - ISSUE: exactly one cycle. `Set`/`Reset` are cleared to `00` at exit, so toggle never repeats. Load the settle counter with `SETTLE`-1 and go to SETTLE.
  - SETTLE: count down.
    - At the edge where the counter is 0: sample `Qs`, update `q_exp`, pulse `done`, pulse `err` if `Qs` ≠ expected, then go to IDLE.
    - `q_exp` takes the expected value, not `Qs`, even on error.
- Hold ops run the full sequence with no J/K pulse and verify `Qs` is unchanged.
- Reset mid-operation aborts immediately: pending commands are discarded and no `done` is produced.

## Timing
- Push at edge 0 into an empty FIFO while IDLE:
  - `Set`/`Reset` high from edge 1 to edge 2.
  - `Qs` sampled at edge 2+`SETTLE`.
  - `done`/`err` high from edge 2+`SETTLE` to edge 3+`SETTLE`.
- Throughput is one command per `SETTLE`+2 cycles; the next pop happens at the edge ending the `done` cycle.
- `cmd_ready` is combinational from registered `level`; no combinational path from `cmd_valid`.
- `Qs` is used only at the sample edge.

## Configuration
- `JK_DRV_CHECK_EN` defined: expected-value tracking, `q_exp`, and the `Qs` comparison are implemented as above.
- Undefined:
  - `err` is tied 0, `q_exp` is tied 0, and `Qs` is unused.
  - `done` timing is identical.

## Test plan
- Release `clear_n`, push set (`10`) at edge 0, model flop drives `Qs`=1 → `ff_clear` low after the first edge; `Set`=1 for exactly one cycle (edges 1–2); `done`=1 with `err`=0 at edge 4 (`SETTLE`=2); `q_exp`=1.
- Push set, reset, toggle, hold back-to-back → J/K patterns `10`,`01`,`11`,`00`, each one cycle; `q_exp` sequence 1,0,1,1; four `done` pulses 4 cycles apart; `err` never asserted.
- With `Qs` stalled, push 5 commands (`DEPTH`=4) → `level` reaches 4; `cmd_ready`=0; the fifth is accepted only after the first pop; order is preserved.
- Force `Qs`=0, push set → `done`=1 and `err`=1 on the same cycle; `q_exp`=1.
- Assert `clear_n`=0 during SETTLE with 2 commands queued → asynchronously `Set`=`Reset`=0, `busy`=0, `level`=0, `ff_clear`=1, `q_exp`=0; no `done` ever appears for the discarded commands.
- Build without `JK_DRV_CHECK_EN`, force `Qs` mismatch → `done` pulses as normal; `err` stays 0.

Source files
------------

// File: rtl/jk_drive_ctrl_if.sv
// Command handshake for jk_drive_ctrl.
// master: command source (drives cmd_valid/cmd_op, sees cmd_ready).
// slave:  the sequencer (accepts commands, drives cmd_ready).
interface jk_drive_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/jk_drive_ctrl.sv
// jk_drive_ctrl: queued command sequencer for a master-slave JK flop.
// Pops hold/reset/set/toggle ops from a small FIFO, drives one-cycle
// J/K (Set/Reset) pulses, waits SETTLE cycles, then samples Qs.
//
// Ports:
//   clk, clear_n     clock, async active-low reset
//   cmd              handshake (cmd_valid, cmd_op, cmd_ready)
//   Set, Reset       registered J/K drive to the flop
//   ff_clear         registered active-high clear to the flop
//   Qs               flop slave output, sampled at end of settle
//   q_exp            expected flop state after last completed op
//   done, err        completion pulse, mismatch pulse
//   busy, level      FSM not idle, FIFO occupancy
//
// Optional: define JK_DRV_CHECK_EN to build the q_exp tracking and
// the Qs comparison; otherwise err and q_exp are tied low.
module jk_drive_ctrl #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   clear_n,
    jk_drive_ctrl_if.slave         cmd,
    output logic                   Set,
    output logic                   Reset,
    output logic                   ff_clear,
    input  logic                   Qs,
    output logic                   q_exp,
    output logic                   done,
    output logic                   err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   L_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] P_ONE    = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic          set_q, set_d;
    logic          rst_q, rst_d;
    logic          clr_q;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          full;
    logic          push;
    logic          pop;
    logic [1:0]    head_op;

    // Ready depends only on registered occupancy; a same-cycle pop
    // does not open a slot.
    assign full          = (level_q == FULL);
    assign cmd.cmd_ready = ~full;
    assign push          = cmd.cmd_valid & ~full;
    assign head_op       = mem_q[rd_q];

`ifdef JK_DRV_CHECK_EN
    logic exp_q, exp_d;
    logic qexp_q, qexp_d;
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        rst_d   = rst_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef JK_DRV_CHECK_EN
        exp_d   = exp_q;
        qexp_d  = qexp_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if ((level_q != '0) && !clr_q) begin
                    pop     = 1'b1;
                    set_d   = head_op[1];
                    rst_d   = head_op[0];
                    state_d = S_ISSUE;
`ifdef JK_DRV_CHECK_EN
                    unique case (head_op)
                        2'b00:   exp_d = qexp_q;
                        2'b01:   exp_d = 1'b0;
                        2'b10:   exp_d = 1'b1;
                        default: exp_d = ~qexp_q;
                    endcase
`endif
                end
            end
            S_ISSUE: begin
                // Drop J/K after one cycle so a toggle fires once.
                set_d   = 1'b0;
                rst_d   = 1'b0;
                cnt_d   = CNT_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
`ifdef JK_DRV_CHECK_EN
                    // Track the intended state even when Qs disagrees.
                    err_d   = (Qs != exp_q);
                    qexp_d  = exp_q;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d    = push ? (wr_q + P_ONE) : wr_q;
        rd_d    = pop ? (rd_q + P_ONE) : rd_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + L_ONE;
        end else if (!push && pop) begin
            level_d = level_q - L_ONE;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            set_q   <= 1'b0;
            rst_q   <= 1'b0;
            clr_q   <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            set_q   <= set_d;
            rst_q   <= rst_d;
            clr_q   <= 1'b0;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            if (push) begin
                mem_q[wr_q] <= cmd.cmd_op;
            end
        end
    end

`ifdef JK_DRV_CHECK_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            exp_q  <= 1'b0;
            qexp_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            exp_q  <= exp_d;
            qexp_q <= qexp_d;
            err_q  <= err_d;
        end
    end

    assign q_exp = qexp_q;
    assign err   = err_q;
`else
    logic unused_qs;
    assign unused_qs = Qs;
    assign q_exp     = 1'b0;
    assign err       = 1'b0;
`endif

    assign Set      = set_q;
    assign Reset    = rst_q;
    assign ff_clear = clr_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);
    assign level    = level_q;

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Testbench for jk_drive_ctrl: directed steps plus randomized ops,
// checked against a command-level scoreboard and a JK flop model.
module tb_jk_drive_ctrl;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int PER    = 10;

`ifdef JK_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          clear_n = 1'b1;
    logic          Set, Reset, ff_clear, Qs;
    logic          q_exp, done, err, busy;
    logic [LW-1:0] level;

    jk_drive_ctrl_if cif ();

    jk_drive_ctrl #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .cmd      (cif.slave),
        .Set      (Set),
        .Reset    (Reset),
        .ff_clear (ff_clear),
        .Qs       (Qs),
        .q_exp    (q_exp),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .level    (level)
    );

    always #(PER / 2) clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural JK flop; Qs may be forced to inject mismatches.
    logic q_ff    = 1'b0;
    logic frc_en  = 1'b0;
    logic frc_val = 1'b0;
    logic qs_edge = 1'b0;

    assign Qs = frc_en ? frc_val : q_ff;

    always @(posedge clk) begin
        if (ff_clear) begin
            q_ff <= 1'b0;
        end else begin
            case ({Set, Reset})
                2'b10:   q_ff <= 1'b1;
                2'b01:   q_ff <= 1'b0;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
        qs_edge <= Qs;
    end

    // Command-level reference: accepted ops in order, expected state.
    logic [1:0] acc_q[$];
    logic [1:0] cur_op    = 2'b00;
    bit         cur_v     = 1'b0;
    bit         prev_busy = 1'b0;
    logic       mq        = 1'b0;
    logic       exp_v     = 1'b0;
    int         cyc       = 0;
    int         issue_t   = 0;

    function automatic logic next_q(input logic [1:0] op, input logic q);
        case (op)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!clear_n) begin
            acc_q.delete();
            cur_v     = 1'b0;
            prev_busy = 1'b0;
            mq        = 1'b0;
            chk("rst_no_done", done, 0);
        end else begin
            if (busy && !prev_busy) begin
                chk("issue_has_cmd", acc_q.size() != 0, 1);
                cur_op  = (acc_q.size() != 0) ? acc_q.pop_front() : 2'b00;
                cur_v   = 1'b1;
                issue_t = cyc;
                exp_v   = next_q(cur_op, mq);
                chk("jk_issue", {Set, Reset}, cur_op);
            end else begin
                chk("jk_quiet", {Set, Reset}, 2'b00);
            end
            if (done) begin
                chk("done_owner", cur_v, 1);
                chk("done_lat", cyc - issue_t, SETTLE + 1);
                chk("err_val", err, CHK && (qs_edge !== exp_v));
                chk("q_exp_val", q_exp, CHK ? exp_v : 1'b0);
                mq    = exp_v;
                cur_v = 1'b0;
            end else begin
                chk("err_alone", err, 0);
            end
            prev_busy = busy;
        end
    end

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic push(input logic [1:0] op);
        int t = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        while (cif.cmd_ready !== 1'b1 && t < 40) begin
            chk("stall_full", level, DEPTH);
            @(negedge clk);
            t++;
        end
        chk("push_accept", cif.cmd_ready, 1);
        if (cif.cmd_ready === 1'b1) acc_q.push_back(op);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'($urandom_range(3));
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done !== 1'b1 && t < 40);
        chk(tag, done, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy !== 1'b0 || level !== '0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", {busy, level}, 0);
        @(negedge clk);
    endtask

    logic [1:0] b2b_ops [4];
    logic       b2b_q   [4];
    logic [1:0] fill_ops [6];

    initial begin
        longint t_prev;
        int gap;
        logic [1:0] op;

        b2b_ops  = '{2'b10, 2'b01, 2'b11, 2'b00};
        b2b_q    = '{1'b1, 1'b0, 1'b1, 1'b1};
        fill_ops = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10};
        t_prev   = 0;

        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        #1 clear_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready", cif.cmd_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_jk", {Set, Reset}, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_qexp", q_exp, 0);
        chk("rst_clear", ff_clear, 1);

        // Release and push a set at the first edge.
        clear_n = 1'b1;
        chk("clr_held", ff_clear, 1);
        push(2'b10);
        chk("clr_off", ff_clear, 0);
        chk("t1_level", level, 1);
        chk("t1_jk0", {Set, Reset}, 2'b00);
        @(negedge clk);
        chk("t1_jk1", {Set, Reset}, 2'b10);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_jk2", {Set, Reset}, 2'b00);
        @(negedge clk);
        chk("t1_nodone3", done, 0);
        @(negedge clk);
        chk("t1_done4", done, 1);
        chk("t1_err4", err, 0);
        chk("t1_qexp4", q_exp, CHK);
        @(negedge clk);
        chk("t1_done5", done, 0);
        chk("t1_idle5", busy, 0);

        // Back-to-back set, reset, toggle, hold.
        for (int k = 0; k < 4; k++) push(b2b_ops[k]);
        for (int k = 0; k < 4; k++) begin
            wait_done("b2b_done");
            chk("b2b_qexp", q_exp, CHK ? b2b_q[k] : 1'b0);
            if (k > 0) begin
                gap = int'(($time - t_prev) / PER);
                chk("b2b_gap", gap, SETTLE + 2);
            end
            t_prev = $time;
        end
        wait_idle();

        // Fill the FIFO beyond capacity; order checked by scoreboard.
        for (int k = 0; k < 5; k++) push(fill_ops[k]);
        chk("fill_level", level, DEPTH);
        chk("fill_ready", cif.cmd_ready, 0);
        push(fill_ops[5]);
        wait_idle();

        // Forced mismatch on a set.
        frc_en  = 1'b1;
        frc_val = 1'b0;
        push(2'b10);
        wait_done("mm_done");
        chk("mm_err", err, CHK);
        chk("mm_qexp", q_exp, CHK);
        @(negedge clk);
        frc_en = 1'b0;
        wait_idle();

        // Abort in SETTLE with two commands still queued.
        push(2'b10);
        push(2'b01);
        push(2'b11);
        chk("ab_busy", busy, 1);
        chk("ab_level", level, 2);
        #2 clear_n = 1'b0;
        #1;
        chk("ab_jk", {Set, Reset}, 2'b00);
        chk("ab_busy0", busy, 0);
        chk("ab_level0", level, 0);
        chk("ab_clear", ff_clear, 1);
        chk("ab_qexp", q_exp, 0);
        chk("ab_ready", cif.cmd_ready, 1);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("ab_no_done", done, 0);
        end
        chk("ab_level_end", level, 0);
        chk("ab_clear_end", ff_clear, 0);

        // Randomized ops, gaps and occasional forced Qs.
        for (int k = 0; k < 150; k++) begin
            op      = 2'($urandom_range(3));
            frc_en  = ($urandom_range(7) == 0);
            frc_val = 1'($urandom_range(1));
            push(op);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        frc_en = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(PER * 20000);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
